// File: rtl/countdown_timer.sv
// countdown_timer: programmable down-counting timer peripheral for the HACK CPU.
// Loads a start value, decrements it once every presc+1 RUN cycles and signals
// expiry with a one-cycle tick plus a sticky expired flag cleared by ack.
// One-shot or periodic (auto-reload) operation, chosen at each expiry.
//
// Build option: define COUNTDOWN_OVERRUN_EN to implement the overrun flag
// (expiry while expired is still pending). Without it, overrun is tied to 0.
module countdown_timer #(
    parameter int width  = 16,
    parameter int pwidth = 8
) (
    input  logic              clk,
    input  logic              reset,     // active-low, asynchronous
    input  logic              load,
    input  logic [width-1:0]  data,
    input  logic [pwidth-1:0] presc,
    input  logic              start,
    input  logic              stop,
    input  logic              periodic,
    input  logic              ack,
    output logic [width-1:0]  count,
    output logic              running,
    output logic              tick,
    output logic              expired,
    output logic              overrun
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [width-1:0]  CNT_ZERO = '0;
    localparam logic [width-1:0]  CNT_ONE  = {{(width-1){1'b0}}, 1'b1};
    localparam logic [pwidth-1:0] PS_ZERO  = '0;
    localparam logic [pwidth-1:0] PS_ONE   = {{(pwidth-1){1'b0}}, 1'b1};

    logic [0:0]        state;
    logic [width-1:0]  reload;
    logic [pwidth-1:0] presc_reg;
    logic [pwidth-1:0] pcnt;

    // decoded per-edge actions
    logic start_go;   // IDLE -> RUN this edge
    logic start_rl;   // start from an exhausted count: refill from reload first
    logic step;       // a RUN cycle that advances the prescaler
    logic dec;        // count decrements this edge
    logic expire;     // the decrement takes count from 1 to 0

    // Resolve load > stop > start priority into single-purpose strobes.
    always_comb begin
        start_go = 1'b0;
        start_rl = 1'b0;
        step     = 1'b0;
        dec      = 1'b0;
        expire   = 1'b0;
        if (!load && !stop) begin
            if (state == IDLE) begin
                if (start) begin
                    if (count != CNT_ZERO) begin
                        start_go = 1'b1;
                    end else if (reload != CNT_ZERO) begin
                        start_go = 1'b1;
                        start_rl = 1'b1;
                    end
                end
            end else begin
                step = 1'b1;
                // count is never 0 in RUN; the guard keeps it from wrapping anyway
                if (pcnt == PS_ZERO && count != CNT_ZERO) begin
                    dec    = 1'b1;
                    expire = (count == CNT_ONE);
                end
            end
        end
    end

    // Run/idle state: load and stop park the timer, one-shot expiry ends the run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (load) begin
            state <= IDLE;
        end else if (stop) begin
            state <= IDLE;
        end else if (start_go) begin
            state <= RUN;
        end else if (expire && !periodic) begin
            state <= IDLE;
        end
    end

    assign running = (state == RUN);

    // Configuration registers captured by load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reload    <= '0;
            presc_reg <= '0;
        end else if (load) begin
            reload    <= data;
            presc_reg <= presc;
        end
    end

    // Prescale counter: counts presc_reg..0, then rearms as count decrements.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= '0;
        end else if (load) begin
            pcnt <= presc;
        end else if (start_rl) begin
            pcnt <= presc_reg;
        end else if (step) begin
            pcnt <= (pcnt == PS_ZERO) ? presc_reg : pcnt - PS_ONE;
        end
    end

    // Main count: load/refill, decrement, and reload-or-park at expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= data;
        end else if (start_rl) begin
            count <= reload;
        end else if (dec) begin
            if (expire) begin
                count <= periodic ? reload : CNT_ZERO;
            end else begin
                count <= count - CNT_ONE;
            end
        end
    end

    // One-cycle expiry pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick <= 1'b0;
        end else begin
            tick <= expire;
        end
    end

    // Sticky expiry flag; a coincident expiry beats ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            expired <= 1'b0;
        end else if (expire) begin
            expired <= 1'b1;
        end else if (ack) begin
            expired <= 1'b0;
        end
    end

`ifdef COUNTDOWN_OVERRUN_EN
    // Overrun: an expiry landed while the previous one was still unacknowledged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (expire && expired && !ack) begin
            overrun <= 1'b1;
        end else if (ack) begin
            overrun <= 1'b0;
        end
    end
`else
    assign overrun = 1'b0;
`endif

endmodule
